// File: rtl/simd_core_pkg.sv
// Shared SIMD core definitions: opcode field geometry and the instruction-word
// type used by the issue queue, the hazard detection unit and decode.
package simd_core_pkg;

   localparam int unsigned INSTR_WIDTH     = 64;
   localparam int unsigned OPCODE_WIDTH    = 5;
   localparam int unsigned OPC_MSB_DEFAULT = 63;

   typedef logic [INSTR_WIDTH-1:0]  instr_t;
   typedef logic [OPCODE_WIDTH-1:0] opcode_t;

   // Opcode field of a default-layout instruction word.
   function automatic opcode_t opcode_of(input instr_t instr);
      return instr[OPC_MSB_DEFAULT -: OPCODE_WIDTH];
   endfunction

endpackage

// File: rtl/simd_instr_fifo_mem.sv
// Issue queue storage: DEPTH x DATA_WIDTH register array, one synchronous
// write port and one asynchronous read port. Contents are not reset.
//   clk   - core clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data (combinational from raddr)
module simd_instr_fifo_mem #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned DEPTH      = 8,
   localparam int unsigned AW        = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Async read port
   assign rdata = mem[raddr];

endmodule

// File: rtl/simd_instr_issue_queue.sv
// Instruction issue queue feeding the IF/ID register ahead of hazard detection.
// Buffers dispatcher instructions, exposes the head entry and advances it into
// IF/ID whenever STALL is low.
//   clk, rst      - core clock, async active-high reset
//   in_valid/in_instr/in_ready - dispatcher handshake
//   STALL         - hold IF/ID and the read pointer
//   flush         - discard queue and IF/ID contents
//   fifo_instr    - head entry (0 when empty), fifo_empty, fifo_count
//   IF_ID_valid/IF_ID_instr/IF_ID_Opcode - IF/ID pipeline register
module simd_instr_issue_queue
   import simd_core_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned OPC_MSB    = OPC_MSB_DEFAULT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   input  logic [DATA_WIDTH-1:0]     in_instr,
   output logic                      in_ready,
   input  logic                      STALL,
   input  logic                      flush,
   output logic [DATA_WIDTH-1:0]     fifo_instr,
   output logic                      fifo_empty,
   output logic [$clog2(DEPTH):0]    fifo_count,
   output logic                      IF_ID_valid,
   output logic [DATA_WIDTH-1:0]     IF_ID_instr,
   output logic [OPCODE_WIDTH-1:0]   IF_ID_Opcode
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [DATA_WIDTH-1:0] head;
   logic                  push;
   logic                  pop;
   logic                  adv;

   // Handshake and advance decode; in_ready sees only the registered count
   // and flush, so a pop cannot open a slot in the same cycle.
   assign in_ready   = (fifo_count != CNT_W'(DEPTH)) & ~flush;
   assign push       = in_valid & in_ready;
   assign adv        = ~STALL & ~flush;
   assign fifo_empty = (fifo_count == CNT_W'(0));
   assign pop        = adv & ~fifo_empty;

   simd_instr_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (in_instr),
      .raddr (rd_ptr),
      .rdata (head)
   );

   // Head view gated so an empty queue never exposes stale storage.
   assign fifo_instr = fifo_empty ? DATA_WIDTH'(0) : head;

   // Pointers and occupancy counter; flush overrides push and pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= PTR_W'(0);
         rd_ptr     <= PTR_W'(0);
         fifo_count <= CNT_W'(0);
      end else if (flush) begin
         wr_ptr     <= PTR_W'(0);
         rd_ptr     <= PTR_W'(0);
         fifo_count <= CNT_W'(0);
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // IF/ID register; an advance with an empty queue inserts a bubble but
   // leaves the instruction word untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         IF_ID_valid <= 1'b0;
         IF_ID_instr <= DATA_WIDTH'(0);
      end else if (flush) begin
         IF_ID_valid <= 1'b0;
      end else if (adv) begin
         if (fifo_empty) begin
            IF_ID_valid <= 1'b0;
         end else begin
            IF_ID_valid <= 1'b1;
            IF_ID_instr <= head;
         end
      end
   end

   assign IF_ID_Opcode = IF_ID_instr[OPC_MSB -: OPCODE_WIDTH];

endmodule
